uart_tx_feeder: RTL and testbench

- Upstream stage of the UART transmitter: buffers bytes from the system side in a small synchronous FIFO.
- Launches one byte at a time into the TX controller using a single-cycle Data_Valid pulse plus a held P_DATA byte.
- Paces launches off the TX Busy flag. Busy is registered inside TX and rises 2 cycles after Data_Valid.
- Guarantees no byte is issued while TX is busy and P_DATA stays stable for the whole frame.

---
 rtl/uart_tx_feeder.sv | 152 +++++++++++++++
 tb/tb_uart_tx_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte buffer in front of the UART TX controller. Bytes from the system side
// are queued in a small synchronous FIFO and handed to TX one at a time: a
// single-cycle Data_Valid pulse, with P_DATA held from that launch until the
// next one. Each launch waits until TX has raised Busy for the current frame
// and then dropped it again.
//
// Ports
//   CLK         system clock (TX clock domain)
//   RST         synchronous active-low reset
//   WR_EN       write request, accepted when not FULL (or when a pop frees a slot)
//   WR_DATA     byte to enqueue
//   Busy        TX busy flag, registered inside TX (rises 2 cycles after Data_Valid)
//   P_DATA      byte presented to TX, changes only on a launch edge
//   Data_Valid  single-cycle launch pulse
//   FULL        FIFO holds DEPTH entries
//   EMPTY       FIFO holds no entries
//   COUNT       current occupancy
//
// State table
//   state        | meaning
//   ST_IDLE      | waiting for a queued byte and Busy=0; launch decision made here
//   ST_LAUNCH    | Data_Valid high for this single cycle
//   ST_WAIT_BUSY | waiting for TX to acknowledge the frame by raising Busy
//   ST_WAIT_DONE | frame in flight; wait for Busy to drop

module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,   // power of two, at least 2
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  Busy,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [PTR_W:0]        COUNT
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Launch sequencing. The pop happens only on the IDLE -> LAUNCH edge, so
    // P_DATA is loaded exactly once per frame and stays put until the next one.
    always_comb begin
        state_d      = state_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !Busy) begin
                    pop          = 1'b1;
                    p_data_d     = mem_q[rd_ptr_q];
                    data_valid_d = 1'b1;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            // Busy lags Data_Valid by two cycles, so it cannot be trusted
            // as "done" until it has been seen high at least once.
            ST_WAIT_BUSY: begin
                if (Busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!Busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. A write while full is still taken when the same
    // cycle pops, since the pop frees the slot the write lands in.
    always_comb begin
        push     = WR_EN && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    // During reset push may still be high, which is harmless since the
    // pointers and count are being cleared.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign COUNT      = count_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: a fixed vector table for reset and single
// bytes, directed sequences for pacing, overflow, simultaneous write/pop and
// reset mid-frame, then randomized traffic against a queue-based reference.

module tb_uart_tx_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          WR_EN;
    logic [DW-1:0] WR_DATA;
    logic          Busy;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          FULL;
    logic          EMPTY;
    logic [PTR_W:0] COUNT;

    always #5 CLK = ~CLK;

    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .Busy       (Busy),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .COUNT      (COUNT)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] d;
        logic       busy;
        logic       dv;
        logic [7:0] pd;
        int         cnt;
        logic       empty;
        logic       full;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   model_en = 1'b0;
    bit   tx_auto  = 1'b0;
    bit   rand_frames = 1'b0;
    int   tx_start = -100;
    int   tx_end   = -100;
    int   dv_log[$];
    logic [7:0] pd_log[$];

    // Reference: the FIFO is a queue; a launch is decided in a cycle where
    // the queue is non-empty, Busy is low and the previous frame is over.
    // A frame is over once Busy was seen high after the pulse cycle and then
    // seen low in a later cycle; the next cycle is free for a new decision.
    logic [7:0] mq[$];
    logic [7:0] m_pdata    = 8'h00;
    int         m_dv_cycle = -1;
    int         idle_from  = 0;
    int         fall_from  = 0;
    bit         wait_rise  = 1'b0;
    bit         wait_fall  = 1'b0;

    vec_t vecs[17];
    vec_t vnone;

    function automatic vec_t mkv(input logic rst, input logic wr, input logic [7:0] d,
                                 input logic busy, input logic dv, input logic [7:0] pd,
                                 input int cnt, input logic empty, input logic full);
        vec_t v;
        v.rst = rst; v.wr = wr; v.d = d; v.busy = busy;
        v.dv = dv; v.pd = pd; v.cnt = cnt; v.empty = empty; v.full = full;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit launch;
        bit accept;
        if (!RST) begin
            mq.delete();
            m_pdata    = 8'h00;
            m_dv_cycle = -1;
            wait_rise  = 1'b0;
            wait_fall  = 1'b0;
            idle_from  = cyc + 1;
            return;
        end
        if (wait_rise && cyc > m_dv_cycle && Busy) begin
            wait_rise = 1'b0;
            wait_fall = 1'b1;
            fall_from = cyc + 1;
        end else if (wait_fall && cyc >= fall_from && !Busy) begin
            wait_fall = 1'b0;
            idle_from = cyc + 1;
        end
        launch = !wait_rise && !wait_fall && cyc >= idle_from && mq.size() > 0 && !Busy;
        accept = WR_EN && (mq.size() < DEPTH || launch);
        if (launch) begin
            m_pdata    = mq.pop_front();
            m_dv_cycle = cyc + 1;
            wait_rise  = 1'b1;
        end
        if (accept) begin
            mq.push_back(WR_DATA);
        end
    endtask

    task automatic tick(input bit use_vec, input vec_t v);
        @(negedge CLK);
        if (model_en) begin
            chk("count", 32'(COUNT), 32'(mq.size()));
            chk("full",  32'(FULL),  32'(mq.size() == DEPTH));
            chk("empty", 32'(EMPTY), 32'(mq.size() == 0));
            chk("dv",    32'(Data_Valid), 32'(cyc == m_dv_cycle));
            chk("pdata", 32'(P_DATA), 32'(m_pdata));
            if (Data_Valid === 1'b1) begin
                chk("dv_while_busy", 32'(Busy), 32'(0));
                dv_log.push_back(cyc);
                pd_log.push_back(P_DATA);
            end
        end
        if (use_vec) begin
            chk("vec_count", 32'(COUNT), 32'(v.cnt));
            chk("vec_empty", 32'(EMPTY), 32'(v.empty));
            chk("vec_full",  32'(FULL),  32'(v.full));
            chk("vec_dv",    32'(Data_Valid), 32'(v.dv));
            chk("vec_pdata", 32'(P_DATA), 32'(v.pd));
        end
        if (tx_auto && Data_Valid === 1'b1) begin
            tx_start = cyc + 2;
            tx_end   = cyc + 1 + (rand_frames ? int'($urandom_range(1, 12)) : 11);
        end
        model_step();
        @(posedge CLK);
        cyc++;
        #1;
        if (tx_auto) begin
            Busy = (cyc >= tx_start && cyc <= tx_end);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, vnone);
        end
    endtask

    initial begin
        int w0;
        int saved_end;
        logic [7:0] exp_b;

        vecs[0]  = mkv(0, 1, 8'h5A, 0,  0, 8'h00, 0, 1, 0);
        vecs[1]  = mkv(0, 1, 8'h5A, 0,  0, 8'h00, 0, 1, 0);
        vecs[2]  = mkv(0, 1, 8'h5A, 0,  0, 8'h00, 0, 1, 0);
        vecs[3]  = mkv(1, 1, 8'hA5, 0,  0, 8'h00, 0, 1, 0);
        vecs[4]  = mkv(1, 0, 8'h00, 0,  0, 8'h00, 1, 0, 0);
        vecs[5]  = mkv(1, 0, 8'h00, 0,  1, 8'hA5, 0, 1, 0);
        vecs[6]  = mkv(1, 0, 8'h00, 0,  0, 8'hA5, 0, 1, 0);
        vecs[7]  = mkv(1, 0, 8'h00, 1,  0, 8'hA5, 0, 1, 0);
        vecs[8]  = mkv(1, 0, 8'h00, 1,  0, 8'hA5, 0, 1, 0);
        vecs[9]  = mkv(1, 0, 8'h00, 0,  0, 8'hA5, 0, 1, 0);
        vecs[10] = mkv(1, 0, 8'h00, 0,  0, 8'hA5, 0, 1, 0);
        vecs[11] = mkv(1, 1, 8'h3C, 0,  0, 8'hA5, 0, 1, 0);
        vecs[12] = mkv(1, 0, 8'h00, 0,  0, 8'hA5, 1, 0, 0);
        vecs[13] = mkv(1, 0, 8'h00, 0,  1, 8'h3C, 0, 1, 0);
        vecs[14] = mkv(1, 0, 8'h00, 1,  0, 8'h3C, 0, 1, 0);
        vecs[15] = mkv(1, 0, 8'h00, 0,  0, 8'h3C, 0, 1, 0);
        vecs[16] = mkv(1, 0, 8'h00, 0,  0, 8'h3C, 0, 1, 0);

        RST = 1'b0; WR_EN = 1'b0; WR_DATA = 8'h00; Busy = 1'b0;
        tick(1'b0, vnone);
        model_en = 1'b1;

        // Reset hold with WR_EN high, then two single-byte frames.
        for (int i = 0; i < 17; i++) begin
            RST = vecs[i].rst; WR_EN = vecs[i].wr; WR_DATA = vecs[i].d; Busy = vecs[i].busy;
            tick(1'b1, vecs[i]);
        end
        WR_EN = 1'b0;

        // Pacing: TX model raises Busy 2 cycles after each pulse for 11 cycles.
        // Pulse-to-pulse: 2 (Busy delay) + 11 (frame) + 1 (fall seen) + 1 (launch) = 15.
        tx_auto = 1'b1;
        dv_log.delete(); pd_log.delete();
        w0 = cyc;
        for (int i = 0; i < 3; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'h11 * (i + 1);
            tick(1'b0, vnone);
        end
        WR_EN = 1'b0;
        for (int i = 0; i < 100 && pd_log.size() < 3; i++) tick(1'b0, vnone);
        run(20);
        chk("pace_pulses", 32'(dv_log.size()), 32'(3));
        if (dv_log.size() >= 3) begin
            chk("pace_latency", 32'(dv_log[0] - w0), 32'(2));
            chk("pace_gap1", 32'(dv_log[1] - dv_log[0]), 32'(15));
            chk("pace_gap2", 32'(dv_log[2] - dv_log[1]), 32'(15));
            chk("pace_b0", 32'(pd_log[0]), 32'(8'h11));
            chk("pace_b1", 32'(pd_log[1]), 32'(8'h22));
            chk("pace_b2", 32'(pd_log[2]), 32'(8'h33));
        end

        // Overflow with Busy held high, then a write coinciding with the launch pop.
        tx_auto = 1'b0; Busy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(i);
            tick(1'b0, vnone);
        end
        WR_EN = 1'b0;
        tick(1'b0, vnone);
        chk("full_count", 32'(COUNT), 32'(8));
        chk("full_flag", 32'(FULL), 32'(1));
        dv_log.delete(); pd_log.delete();
        tx_auto = 1'b1; Busy = 1'b0;
        WR_EN = 1'b1; WR_DATA = 8'hEE;
        tick(1'b0, vnone);
        WR_EN = 1'b0;
        chk("simul_count", 32'(COUNT), 32'(8));
        chk("simul_full", 32'(FULL), 32'(1));
        chk("simul_dv", 32'(Data_Valid), 32'(1));
        for (int i = 0; i < 400 && pd_log.size() < 9; i++) tick(1'b0, vnone);
        chk("drain_n", 32'(pd_log.size()), 32'(9));
        for (int i = 0; i < 9 && i < pd_log.size(); i++) begin
            exp_b = (i < 8) ? 8'(i) : 8'hEE;
            chk("drain_byte", 32'(pd_log[i]), 32'(exp_b));
        end
        run(20);

        // Reset while a frame is in flight with 3 bytes still queued.
        dv_log.delete(); pd_log.delete();
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'h41 + 8'(i);
            tick(1'b0, vnone);
        end
        WR_EN = 1'b0;
        for (int i = 0; i < 20 && dv_log.size() < 1; i++) tick(1'b0, vnone);
        run(4);
        chk("mid_count", 32'(COUNT), 32'(3));
        RST = 1'b0;
        tick(1'b0, vnone);
        RST = 1'b1;
        chk("rst_count", 32'(COUNT), 32'(0));
        chk("rst_empty", 32'(EMPTY), 32'(1));
        chk("rst_pdata", 32'(P_DATA), 32'(0));
        saved_end = tx_end;
        dv_log.delete(); pd_log.delete();
        WR_EN = 1'b1; WR_DATA = 8'h5C;
        tick(1'b0, vnone);
        WR_EN = 1'b0;
        for (int i = 0; i < 40 && dv_log.size() < 1; i++) tick(1'b0, vnone);
        chk("post_rst_n", 32'(dv_log.size()), 32'(1));
        if (dv_log.size() >= 1) begin
            chk("post_rst_byte", 32'(pd_log[0]), 32'(8'h5C));
            chk("post_rst_time", 32'(dv_log[0]), 32'(saved_end + 2));
        end
        run(20);

        // Random traffic with random frame lengths and occasional resets.
        rand_frames = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            RST     = ($urandom_range(0, 199) != 0);
            WR_EN   = ($urandom_range(0, 1) == 1);
            WR_DATA = 8'($urandom_range(0, 255));
            tick(1'b0, vnone);
        end
        RST = 1'b1; WR_EN = 1'b0;
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
